// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer: FSM states, reset cause
// codes and the counter-width rule.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'b00,
    CAUSE_EXT = 2'b01,
    CAUSE_BTN = 2'b10,
    CAUSE_WDT = 2'b11
  } cause_t;

  // Width that holds 0..max_val. It is never below 1, so a zero-valued
  // parameter still yields a legal vector.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Board-facing signals of the reset sequencer: pushbutton, watchdog kick,
// per-domain resets, ready flag and last reset cause.
interface reset_sequencer_if #(
  parameter int NUM_DOMAINS = 3
) ();
  import reset_sequencer_pkg::*;

  logic                   btn_n;
  logic                   wdt_kick;
  logic [NUM_DOMAINS-1:0] rst_out;
  logic                   ready;
  cause_t                 cause;

  modport master (input btn_n, wdt_kick, output rst_out, ready, cause);
  modport slave  (output btn_n, wdt_kick, input rst_out, ready, cause);

endinterface

// File: rtl/reset_sequencer_btn_debounce.sv
// Pushbutton conditioning: a 2-FF synchroniser followed by a stable-level
// counter. The debounced state changes only after DEBOUNCE_CYCLES consecutive
// synchronised samples at the new level, so shorter glitches are ignored.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic pressed
);
  import reset_sequencer_pkg::*;

  localparam int             CW       = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Power-up values: synchroniser idle high, button released.
  logic          sync_1 = 1'b1;
  logic          sync_2 = 1'b1;
  logic [CW-1:0] cnt    = '0;
  logic          state  = 1'b0;
  logic          sample_pressed;

  assign sample_pressed = ~sync_2;
  assign pressed        = state;

  // Bring the asynchronous active-low button into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= btn_n;
      sync_2 <= sync_1;
    end
  end

  // Count consecutive samples that disagree with the debounced state; flip on the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      state <= 1'b0;
    end else if (sample_pressed == state) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      state <= sample_pressed;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Multi-domain reset source. Holds every domain in reset after power-up or a
// trigger (external reset, debounced button, watchdog), then releases domains
// in a fixed staggered order, domain 0 first, and records the reset cause.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_HOLD    | all domains in reset; cnt counts trigger-free cycles
//   ST_RELEASE | domain 0 released; next domain (idx) freed every stagger
//   ST_RUN     | all domains released, ready=1, watchdog armed
module reset_sequencer import reset_sequencer_pkg::*; #(
  parameter int NUM_DOMAINS     = 3,
  parameter int POR_CYCLES      = 256,
  parameter int STAGGER_CYCLES  = 16,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int WDT_CYCLES      = 0
) (
  input  logic               clk,
  input  logic               reset,
  reset_sequencer_if.master  bus
);

  localparam int                HOLD_W    = cnt_w(POR_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(POR_CYCLES - 1);
  localparam int                STAG_W    = cnt_w(STAGGER_CYCLES);
  localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER_CYCLES - 1);
  localparam int                IDX_W     = cnt_w(NUM_DOMAINS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  // Power-up state comes from these initial register values.
  state_t                 state   = ST_HOLD;
  logic [HOLD_W-1:0]      cnt     = '0;
  logic [STAG_W-1:0]      stag    = '0;
  logic [IDX_W-1:0]       idx     = '0;
  logic [NUM_DOMAINS-1:0] rst_q   = '1;
  logic                   ready_q = 1'b0;
  cause_t                 cause_q = CAUSE_POR;

  state_t                 state_nxt;
  logic [HOLD_W-1:0]      cnt_nxt;
  logic [STAG_W-1:0]      stag_nxt;
  logic [IDX_W-1:0]       idx_nxt;
  logic [NUM_DOMAINS-1:0] rst_nxt;
  logic                   ready_nxt;
  cause_t                 cause_nxt;

  logic btn_pressed;
  logic wdt_expire;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .reset  (reset),
    .btn_n  (bus.btn_n),
    .pressed(btn_pressed)
  );

  if (WDT_CYCLES > 0) begin : g_wdt
    localparam int               WDT_W    = cnt_w(WDT_CYCLES);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt = '0;

    // A kick in the would-be expiry cycle suppresses the expiry.
    assign wdt_expire = (state == ST_RUN) && !bus.wdt_kick && (wdt_cnt == WDT_LAST);

    // Count unkicked RUN cycles; anything outside RUN clears the count.
    always_ff @(posedge clk) begin
      if (reset || state != ST_RUN || bus.wdt_kick || wdt_cnt == WDT_LAST) begin
        wdt_cnt <= '0;
      end else begin
        wdt_cnt <= wdt_cnt + 1'b1;
      end
    end
  end else begin : g_no_wdt
    logic wdt_kick_unused;
    assign wdt_kick_unused = bus.wdt_kick;
    assign wdt_expire      = 1'b0;
  end

  // Next-state and next-output decode; button and watchdog triggers override the sequence.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stag_nxt  = stag;
    idx_nxt   = idx;
    rst_nxt   = rst_q;
    ready_nxt = ready_q;
    cause_nxt = cause_q;
    if (btn_pressed || wdt_expire) begin
      state_nxt = ST_HOLD;
      cnt_nxt   = '0;
      stag_nxt  = '0;
      idx_nxt   = '0;
      rst_nxt   = '1;
      ready_nxt = 1'b0;
      cause_nxt = btn_pressed ? CAUSE_BTN : CAUSE_WDT;
    end else begin
      case (state)
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            rst_nxt[0] = 1'b0;
            cnt_nxt    = '0;
            if (NUM_DOMAINS == 1) begin
              ready_nxt = 1'b1;
              state_nxt = ST_RUN;
            end else begin
              idx_nxt   = IDX_W'(1);
              stag_nxt  = STAG_LAST;
              state_nxt = ST_RELEASE;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (stag == '0) begin
            rst_nxt[idx] = 1'b0;
            if (idx == IDX_LAST) begin
              ready_nxt = 1'b1;
              state_nxt = ST_RUN;
            end else begin
              idx_nxt  = idx + 1'b1;
              stag_nxt = STAG_LAST;
            end
          end else begin
            stag_nxt = stag - 1'b1;
          end
        end
        ST_RUN: begin
        end
        default: begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
          stag_nxt  = '0;
          idx_nxt   = '0;
          rst_nxt   = '1;
          ready_nxt = 1'b0;
        end
      endcase
    end
  end

  // FSM state register; external reset forces a fresh hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_HOLD;
    end else begin
      state <= state_nxt;
    end
  end

  // Counters and registered outputs; external reset wins over all other causes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      stag    <= '0;
      idx     <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      cause_q <= CAUSE_EXT;
    end else begin
      cnt     <= cnt_nxt;
      stag    <= stag_nxt;
      idx     <= idx_nxt;
      rst_q   <= rst_nxt;
      ready_q <= ready_nxt;
      cause_q <= cause_nxt;
    end
  end

  assign bus.rst_out = rst_q;
  assign bus.ready   = ready_q;
  assign bus.cause   = cause_q;

endmodule
